lcd_bus_capture: RTL

Downstream consumer of the character-LCD bus (LCD_RS, LCD_E, LCD_D) driven by the 64-bit hex display driver. Decodes HD44780-style commands and data writes on each LCD_E falling edge and keeps a 2x40 DDRAM image. Exposes the visible 2x16 window through a registered read port, so the simulator host can mirror the board LCD. Same clock domain as the driver; no synchronisers.

---
 rtl/lcd_pkg.sv | 54 +++++
 rtl/lcd_ddram.sv | 39 +++
 rtl/lcd_bus_capture.sv | 125 ++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, command classes and address-counter helpers for the LCD bus capture
package lcd_pkg;

    localparam logic [7:0] LCD_SPACE  = 8'h20;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam logic [6:0] LINE_END   = 7'h27;
    localparam logic [6:0] LINE2_END  = LINE2_BASE + LINE_END;

    // hex2char-compatible digit and letter bases
    localparam logic [7:0] CHAR_0 = 8'h30;
    localparam logic [7:0] CHAR_A = 8'h41;

    localparam logic [3:0] CMD_NONE  = 4'd0;
    localparam logic [3:0] CMD_CLEAR = 4'd1;
    localparam logic [3:0] CMD_HOME  = 4'd2;
    localparam logic [3:0] CMD_ENTRY = 4'd3;
    localparam logic [3:0] CMD_DISP  = 4'd4;
    localparam logic [3:0] CMD_SHIFT = 4'd5;
    localparam logic [3:0] CMD_FUNC  = 4'd6;
    localparam logic [3:0] CMD_CGRAM = 4'd7;
    localparam logic [3:0] CMD_DDRAM = 4'd8;

    typedef enum logic {IDLE, CLEAR} lcd_state_t;

    function automatic logic [7:0] hex2char(input logic [3:0] n);
        return n < 4'd10 ? CHAR_0 + 8'(n) : CHAR_A + 8'(n - 4'd10);
    endfunction

    // the highest set bit of a command byte selects its class
    function automatic logic [3:0] cmd_class(input logic [7:0] d);
        return d[7] ? CMD_DDRAM :
               d[6] ? CMD_CGRAM :
               d[5] ? CMD_FUNC  :
               d[4] ? CMD_SHIFT :
               d[3] ? CMD_DISP  :
               d[2] ? CMD_ENTRY :
               d[1] ? CMD_HOME  :
               d[0] ? CMD_CLEAR : CMD_NONE;
    endfunction

    function automatic logic ac_legal(input logic [6:0] a);
        return (a <= LINE_END) || (a >= LINE2_BASE && a <= LINE2_END);
    endfunction

    // line ends wrap onto the other line; an illegal address never moves
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        if (!ac_legal(a))
            return a;
        if (inc)
            return a == LINE_END ? LINE2_BASE : a == LINE2_END ? 7'h00 : a + 7'd1;
        return a == 7'h00 ? LINE2_END : a == LINE2_BASE ? LINE_END : a - 7'd1;
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// lcd_ddram: 80x8 character store with a sync write port and a registered, blankable read port
module lcd_ddram
    import lcd_pkg::*;
#(
    parameter int DEPTH = 80
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [6:0] waddr,
    input  logic [7:0] wdata,
    input  logic [6:0] raddr,
    input  logic       rd_en,
    output logic [7:0] rd_data
);

    logic [7:0] cells [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : cell_g
        logic [7:0] q;
        // each cell resets to a blank and takes the write port when addressed
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                q <= LCD_SPACE;
            else if (we && waddr == 7'(g))
                q <= wdata;
        end
        assign cells[g] = q;
    end

    // registered read; a disabled read shows a blank
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rd_data <= LCD_SPACE;
        else
            rd_data <= rd_en ? cells[raddr] : LCD_SPACE;
    end

endmodule

// File: rtl/lcd_bus_capture.sv
// lcd_bus_capture: decodes HD44780-style bus strobes into a 2x40 DDRAM image with a visible-window read port
module lcd_bus_capture
    import lcd_pkg::*;
#(
    parameter int VIS_COLS = 16,
    parameter int LINE_LEN = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       LCD_RS,
    input  logic       LCD_E,
    input  logic [7:0] LCD_D,
    input  logic       rd_row,
    input  logic [3:0] rd_col,
    output logic [7:0] rd_char,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic [6:0] cursor_addr,
    output logic       busy,
    output logic       dirty,
    input  logic       dirty_clr,
    output logic       err_busy
);

    localparam logic [6:0] LAST_IDX = 7'(2 * LINE_LEN - 1);

    lcd_state_t state;
    logic       e_q;
    logic       inc;
    logic       cg_mode;
    logic [6:0] clr_idx;
    logic       strobe;
    logic       idle_strobe;
    logic [3:0] cmd;
    logic       wr_ok;
    logic       disp_chg;
    logic       we;
    logic [6:0] waddr;
    logic [7:0] wdata;
    logic [6:0] raddr;
    logic       rd_en;

    assign strobe      = e_q & ~LCD_E;
    assign idle_strobe = strobe && state == IDLE;
    assign cmd         = cmd_class(LCD_D);
    assign busy        = state == CLEAR;

    // write-port steering: the clear sweep owns the port while it runs
    always_comb begin
        wr_ok    = idle_strobe && LCD_RS && !cg_mode && ac_legal(cursor_addr);
        disp_chg = idle_strobe && !LCD_RS && cmd == CMD_DISP &&
                   LCD_D[2:0] != {disp_on, cursor_on, blink_on};
        we       = busy || wr_ok;
        waddr    = busy ? clr_idx :
                   cursor_addr[6] ? 7'(LINE_LEN) + {1'b0, cursor_addr[5:0]} : {1'b0, cursor_addr[5:0]};
        wdata    = busy ? LCD_SPACE : LCD_D;
        raddr    = rd_row ? 7'(LINE_LEN) + {3'b0, rd_col} : {3'b0, rd_col};
        rd_en    = disp_on && ({3'b0, rd_col} < 7'(VIS_COLS));
    end

    // strobe decode, clear sequencing and sticky flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q         <= 1'b0;
            state       <= IDLE;
            clr_idx     <= 7'd0;
            cursor_addr <= 7'd0;
            inc         <= 1'b1;
            disp_on     <= 1'b0;
            cursor_on   <= 1'b0;
            blink_on    <= 1'b0;
            cg_mode     <= 1'b0;
            dirty       <= 1'b1;
            err_busy    <= 1'b0;
        end else begin
            e_q   <= LCD_E;
            dirty <= we || disp_chg || (dirty && !dirty_clr);
            if (state == CLEAR) begin
                if (strobe)
                    err_busy <= 1'b1;
                if (clr_idx == LAST_IDX) begin
                    state   <= IDLE;
                    clr_idx <= 7'd0;
                end else begin
                    clr_idx <= clr_idx + 7'd1;
                end
            end else if (strobe && LCD_RS) begin
                if (wr_ok)
                    cursor_addr <= ac_step(cursor_addr, inc);
            end else if (strobe) begin
                case (cmd)
                    CMD_CLEAR: begin
                        state       <= CLEAR;
                        clr_idx     <= 7'd0;
                        cursor_addr <= 7'd0;
                        inc         <= 1'b1;
                    end
                    CMD_HOME:  cursor_addr <= 7'd0;
                    CMD_ENTRY: inc <= LCD_D[1];
                    CMD_DISP:  {disp_on, cursor_on, blink_on} <= LCD_D[2:0];
                    CMD_SHIFT: if (!LCD_D[3]) cursor_addr <= ac_step(cursor_addr, LCD_D[2]);
                    CMD_CGRAM: cg_mode <= 1'b1;
                    CMD_DDRAM: begin
                        cursor_addr <= LCD_D[6:0];
                        cg_mode     <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    lcd_ddram #(.DEPTH(2 * LINE_LEN)) u_ddram (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr   (raddr),
        .rd_en   (rd_en),
        .rd_data (rd_char)
    );

endmodule
